// File: rtl/producer2riscv.sv
// Inbound stream port: buffers upstream words in a small FIFO and serves them to the core as a
// blocking-read data register plus a status register. Optional read timeout: PRODUCER2RISCV_TIMEOUT_EN.
module producer2riscv #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_LOG2     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  val_in,
  output logic                  ready_upward,
  input  logic                  bus_sel,
  input  logic                  bus_reg,
  output logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count, count_next;
  logic                    empty, full, push, pop, capture;
  logic [DATA_WIDTH-1:0]   capture_data, status_word;
  logic                    timeout_flag;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign push      = val_in && ready_upward;
  assign bus_ready = (state == ACK);

  always_comb begin
    status_word                     = '0;
    status_word[0]                  = !empty;
    status_word[1]                  = full;
    status_word[2]                  = timeout_flag;
    status_word[8 +: DEPTH_LOG2+1]  = count;
  end

`ifdef PRODUCER2RISCV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timeout_count;
  logic          stall, timeout_fire, status_read;
`endif

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    capture      = 1'b0;
    capture_data = status_word;
`ifdef PRODUCER2RISCV_TIMEOUT_EN
    stall        = 1'b0;
    timeout_fire = 1'b0;
    status_read  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus_sel) begin
          if (bus_reg) begin
            capture    = 1'b1;
            state_next = ACK;
`ifdef PRODUCER2RISCV_TIMEOUT_EN
            status_read = 1'b1;
`endif
          end else if (!empty) begin
            capture      = 1'b1;
            capture_data = mem[rd_ptr];
            pop          = 1'b1;
            state_next   = ACK;
          end else begin
`ifdef PRODUCER2RISCV_TIMEOUT_EN
            // Give up on the stalled read; a word pushed this same cycle stays queued.
            stall = 1'b1;
            if (timeout_count == TIMEOUT_LAST) begin
              timeout_fire = 1'b1;
              capture      = 1'b1;
              capture_data = '1;
              state_next   = ACK;
            end
`endif
          end
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ready_upward <= 1'b0;
      bus_rdata    <= '0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      ready_upward <= (count_next != FULL_COUNT);
      if (push)    wr_ptr    <= wr_ptr + 1'b1;
      if (pop)     rd_ptr    <= rd_ptr + 1'b1;
      if (capture) bus_rdata <= capture_data;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= din;
  end

`ifdef PRODUCER2RISCV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_count <= '0;
      timeout_flag  <= 1'b0;
    end else begin
      if (stall && !timeout_fire) timeout_count <= timeout_count + 1'b1;
      else                        timeout_count <= '0;
      // The status read samples the flag at this same edge, so it is seen once before clearing.
      if (timeout_fire)     timeout_flag <= 1'b1;
      else if (status_read) timeout_flag <= 1'b0;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_producer2riscv.sv
// Bench for producer2riscv: randomized pushes/reads, a reference FIFO model feeding an expected
// queue, and a monitor that checks every bus_ready response. Timeout case under PRODUCER2RISCV_TIMEOUT_EN.
module tb_producer2riscv;

  localparam int DW     = 32;
  localparam int DL2    = 2;
  localparam int DEPTH  = 4;
  localparam int TO     = 16;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din;
  logic          val_in;
  logic          ready_upward;
  logic          bus_sel;
  logic          bus_reg;
  logic          bus_ready;
  logic [DW-1:0] bus_rdata;

  producer2riscv #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .din(din), .val_in(val_in), .ready_upward(ready_upward),
    .bus_sel(bus_sel), .bus_reg(bus_reg), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  bit            pending = 1'b0;
  bit            sticky_model = 1'b0;
  int            total = 0;
  int            passed = 0;
  int            acc_cyc, rdy_cyc;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] status_model();
    int            n;
    logic [DW-1:0] s;
    n = model_q.size();
    s = DW'(n * 256);
    if (n > 0)        s = s + 1;
    if (n == DEPTH)   s = s + 2;
    if (sticky_model) s = s + 4;
    return s;
  endfunction

  // driver tasks
  task automatic push_word(input logic [DW-1:0] w);
    int waited;
    waited = 0;
    @(negedge clk);
    din    = w;
    val_in = 1'b1;
    while (!ready_upward && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_upward) begin
      check("push_accept_timeout", ready_upward, 1);
      val_in = 1'b0;
      return;
    end
    if (pending) begin
      exp_q.push_back(w);
      pending = 1'b0;
    end else begin
      model_q.push_back(w);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    val_in  = 1'b0;
  endtask

  // kind: 0 = data read, 1 = status read, 2 = data read with expectation supplied by caller
  task automatic bus_access(input int kind, output int lat);
    @(negedge clk);
    if (kind == 1) begin
      exp_q.push_back(status_model());
      sticky_model = 1'b0;
    end else if (kind == 0) begin
      if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      else pending = 1'b1;
    end
    bus_sel = 1'b1;
    bus_reg = (kind == 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_ready && lat < BUDGET);
    if (!bus_ready) check("bus_ready_timeout", bus_ready, 1);
    rdy_cyc = cyc;
    bus_sel = 1'b0;
    bus_reg = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_response: got bus_rdata %h required no bus_ready", bus_rdata);
      end else begin
        check("rdata", bus_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    int lat, occ;
    resetn  = 1'b0;
    din     = '0;
    val_in  = 1'b0;
    bus_sel = 1'b0;
    bus_reg = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready_upward", ready_upward, 0);
    check("reset_bus_ready", bus_ready, 0);
    check("reset_bus_rdata", bus_rdata, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_release", ready_upward, 1);

    // in-order data reads, one-cycle latency
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    for (int i = 0; i < 3; i++) begin
      bus_access(0, lat);
      check("t1_latency", lat, 1);
    end
    bus_access(1, lat);

    // fill to full, then a pop releases the fifth word
    for (int i = 0; i < 4; i++) push_word($urandom);
    check("t2_full_ready", ready_upward, 0);
    bus_access(1, lat);
    fork
      push_word($urandom);
      begin
        bus_access(0, lat);
        check("t2_ready_after_pop", ready_upward, 1);
      end
    join
    while (model_q.size() > 0) begin
      bus_access(0, lat);
      check("t2_latency", lat, 1);
    end

    // stalled read released by a late push
    fork
      bus_access(0, lat);
      begin
        repeat (5) @(negedge clk);
        push_word(32'hCAFEF00D);
      end
    join
    check("t3_edges_accept_to_ready", DW'(rdy_cyc - acc_cyc), 1);
    bus_access(1, lat);

    // simultaneous push/pop at random occupancy, across pointer wrap
    for (int i = 0; i < 8; i++) begin
      occ = $urandom_range(1, DEPTH);
      while (model_q.size() < occ) push_word($urandom);
      while (model_q.size() > occ) bus_access(0, lat);
      fork
        push_word($urandom);
        bus_access(0, lat);
      join
      check("t4_pop_latency", lat, 1);
      bus_access(1, lat);
    end
    while (model_q.size() > 0) bus_access(0, lat);

    // reset in the middle of an access
    push_word(32'hA5A5A5A5);
    push_word(32'h5A5A5A5A);
    bus_access(0, lat);
    push_word(32'h00001234);
    @(negedge clk);
    bus_sel = 1'b1;
    bus_reg = 1'b0;
    resetn  = 1'b0;
    @(negedge clk);
    check("t5_bus_ready", bus_ready, 0);
    check("t5_bus_rdata", bus_rdata, 0);
    check("t5_ready_upward", ready_upward, 0);
    bus_sel = 1'b0;
    resetn  = 1'b1;
    model_q.delete();
    pending = 1'b0;
    @(negedge clk);
    check("t5_ready_after_release", ready_upward, 1);
    bus_access(1, lat);

`ifdef PRODUCER2RISCV_TIMEOUT_EN
    exp_q.push_back('1);
    bus_access(2, lat);
    check("t6_timeout_latency", lat, TO);
    sticky_model = 1'b1;
    bus_access(1, lat);
    bus_access(1, lat);
`endif

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
